w_sched_stream: RTL and testbench

//  Parametrised SHA-2 message-schedule generator: accepts one 16-word block, then streams W[0..ROUNDS-1] one word/cycle
//  to the round-compression datapath over a valid/ready handshake. Successor to the fixed 32-bit init/next expander:

---
 rtl/w_sched_stream.sv | 115 +++++++++++
 tb/tb_w_sched_stream.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_sched_stream.sv
// SHA-2 message-schedule streamer: loads one 16-word block, then emits
// W[0..ROUNDS-1] one word per accepted beat over valid/ready.
// Optional feature macro: WSCHED_BACKPRESSURE_EN adds the w_ready input;
// without it the consumer is assumed always ready.
module w_sched_stream #(
    parameter  int WORD_W = 32,
    parameter  int ROUNDS = 64,
    localparam int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 abort,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [16*WORD_W-1:0] block,
    output logic                 w_valid,
`ifdef WSCHED_BACKPRESSURE_EN
    input  logic                 w_ready,
`endif
    output logic [WORD_W-1:0]    w_out,
    output logic [IDX_W-1:0]     w_idx,
    output logic                 w_last,
    output logic                 busy
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word
        $error("w_sched_stream: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
        $error("w_sched_stream: ROUNDS must be in 16..80");
    end

`ifndef WSCHED_BACKPRESSURE_EN
    // Consumer is always ready when backpressure is compiled out.
    logic w_ready;
    assign w_ready = 1'b1;
`endif

    // Rotate/shift amounts for the small sigma functions of each word size.
    localparam int S0_A = (WORD_W == 64) ? 1  : 7;
    localparam int S0_B = (WORD_W == 64) ? 8  : 18;
    localparam int S0_S = (WORD_W == 64) ? 7  : 3;
    localparam int S1_A = (WORD_W == 64) ? 19 : 17;
    localparam int S1_B = (WORD_W == 64) ? 61 : 19;
    localparam int S1_S = (WORD_W == 64) ? 6  : 10;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state, state_nxt;
    logic [15:0][WORD_W-1:0]      win;
    logic [IDX_W-1:0]             idx;
    logic [WORD_W-1:0]            w_new;
    logic                         take_blk, take_w, at_last;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
    endfunction

    // Outputs and handshakes are pure functions of state, index and window.
    always_comb begin
        at_last   = (idx == LAST);
        w_valid   = (state == RUN);
        busy      = (state == RUN);
        w_last    = w_valid && at_last;
        w_idx     = idx;
        w_out     = w_valid ? win[0] : '0;
        blk_ready = (state == IDLE) | (w_last & w_ready);
        take_blk  = blk_valid & blk_ready;
        take_w    = w_valid & w_ready;
        w_new     = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // Next state: a new block wins over finishing; abort overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take_blk) state_nxt = RUN;
            RUN:  if (take_w && at_last && !take_blk) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Window and round index: load on block accept, slide one word per beat.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            win <= '0;
            idx <= '0;
        end else if (abort) begin
            idx <= '0;
        end else if (take_blk) begin
            win <= block;
            idx <= '0;
        end else if (take_w) begin
            win <= {w_new, win[15:1]};
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_w_sched_stream.sv
// Bench for w_sched_stream: a 32-bit/64-round and a 64-bit/80-round instance,
// checked against a full-array SHA-2 schedule model.
module tb_w_sched_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic blk_valid = 1'b0;
    logic w_ready = 1'b1;
    int   sel = 0;
    int   rounds = 64;

    logic [511:0]  blk32 = '0;
    logic [1023:0] blk64 = '0;
    logic          r32, v32, l32, b32, r64, v64, l64, b64;
    logic [31:0]   o32;
    logic [63:0]   o64;
    logic [5:0]    i32;
    logic [6:0]    i64;

    logic          o_valid, o_ready, o_last, o_busy;
    logic [63:0]   o_out;
    int            o_idx;

    logic [63:0]   bw[16];
    logic [63:0]   mw[80];
    int            n_cmp = 0;
    int            n_mis = 0;

    always #5 clk = ~clk;

    w_sched_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .clk(clk), .Reset(rst_n), .abort(abort && sel == 0),
        .blk_valid(blk_valid && sel == 0), .blk_ready(r32), .block(blk32),
        .w_valid(v32),
`ifdef WSCHED_BACKPRESSURE_EN
        .w_ready(w_ready),
`endif
        .w_out(o32), .w_idx(i32), .w_last(l32), .busy(b32));

    w_sched_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk(clk), .Reset(rst_n), .abort(abort && sel == 1),
        .blk_valid(blk_valid && sel == 1), .blk_ready(r64), .block(blk64),
        .w_valid(v64),
`ifdef WSCHED_BACKPRESSURE_EN
        .w_ready(w_ready),
`endif
        .w_out(o64), .w_idx(i64), .w_last(l64), .busy(b64));

    // Observe whichever instance is under test.
    always_comb begin
        o_valid = sel != 0 ? v64 : v32;
        o_ready = sel != 0 ? r64 : r32;
        o_last  = sel != 0 ? l64 : l32;
        o_busy  = sel != 0 ? b64 : b32;
        o_out   = sel != 0 ? o64 : {32'b0, o32};
        o_idx   = sel != 0 ? int'(i64) : int'(i32);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    // Textbook schedule recurrence over the whole word array.
    task automatic model;
        int w = (sel != 0) ? 64 : 32;
        logic [63:0] m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        logic [63:0] s0, s1;
        for (int t = 0; t < 16; t++) mw[t] = bw[t] & m;
        for (int t = 16; t < 80; t++) begin
            if (w == 64) begin
                s0 = rotr(mw[t-15], 1, 64) ^ rotr(mw[t-15], 8, 64) ^ (mw[t-15] >> 7);
                s1 = rotr(mw[t-2], 19, 64) ^ rotr(mw[t-2], 61, 64) ^ (mw[t-2] >> 6);
            end else begin
                s0 = rotr(mw[t-15], 7, 32) ^ rotr(mw[t-15], 18, 32) ^ (mw[t-15] >> 3);
                s1 = rotr(mw[t-2], 17, 32) ^ rotr(mw[t-2], 19, 32) ^ (mw[t-2] >> 10);
            end
            mw[t] = (s1 + mw[t-7] + s0 + mw[t-16]) & m;
        end
    endtask

    task automatic pack;
        for (int i = 0; i < 16; i++) begin
            blk32[32*i +: 32] = bw[i][31:0];
            blk64[64*i +: 64] = bw[i];
        end
    endtask

    task automatic rand_block;
        for (int i = 0; i < 16; i++) bw[i] = {$urandom, $urandom};
    endtask

    // Offer the packed block and return on the sample after it is taken.
    task automatic offer;
        int k = 0;
        blk_valid = 1'b1;
        while (!o_ready && k < 200) begin tick; k++; end
        if (k >= 200) chk("offer_timeout", 64'd1, 64'd0);
        tick;
        blk_valid = 1'b0;
    endtask

    task automatic expect_stream(input logic [63:0] e[80], input int first, input int last, input bit end_idle);
        for (int t = first; t <= last; t++) begin
            chk("w_valid", {63'b0, o_valid}, 64'd1);
            chk("w_idx", 64'(o_idx), 64'(t));
            chk("w_out", o_out, e[t]);
            chk("w_last", {63'b0, o_last}, {63'b0, t == rounds - 1});
            tick;
        end
        if (end_idle) begin
            chk("idle_valid", {63'b0, o_valid}, 64'd0);
            chk("idle_busy", {63'b0, o_busy}, 64'd0);
            chk("idle_ready", {63'b0, o_ready}, 64'd1);
        end
    endtask

    typedef struct {
        int          vsel;
        logic [63:0] w0;
        logic [63:0] w15;
        int          idx;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl[9];
    logic [63:0] cap[80];
    logic [63:0] e_a[80];
    int          nw, last_at, k;

    initial begin
        tbl[0] = '{0, 64'h61626380, 64'h18, 0,  64'h61626380};
        tbl[1] = '{0, 64'h61626380, 64'h18, 15, 64'h00000018};
        tbl[2] = '{0, 64'h61626380, 64'h18, 16, 64'h61626380};
        tbl[3] = '{0, 64'h61626380, 64'h18, 17, 64'h000F0000};
        tbl[4] = '{0, 64'h0, 64'h0, 0,  64'h0};
        tbl[5] = '{0, 64'h0, 64'h0, 63, 64'h0};
        tbl[6] = '{1, 64'h0, 64'h0, 0,  64'h0};
        tbl[7] = '{1, 64'h0, 64'h0, 40, 64'h0};
        tbl[8] = '{1, 64'h0, 64'h0, 79, 64'h0};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_ready", {63'b0, o_ready}, 64'd1);
            chk("rst_valid", {63'b0, o_valid}, 64'd0);
            chk("rst_out", o_out, 64'd0);
            chk("rst_idx", 64'(o_idx), 64'd0);
            chk("rst_last", {63'b0, o_last}, 64'd0);
            chk("rst_busy", {63'b0, o_busy}, 64'd0);
        end

        // Table vectors: known words of the "abc" and all-zero blocks.
        foreach (tbl[v]) begin
            sel = tbl[v].vsel;
            rounds = (sel != 0) ? 80 : 64;
            for (int i = 0; i < 16; i++) bw[i] = '0;
            bw[0] = tbl[v].w0;
            bw[15] = tbl[v].w15;
            pack;
            #1;
            for (int i = 0; i < 80; i++) cap[i] = 'x;
            nw = 0; last_at = -1; k = 0;
            offer;
            while (o_valid && k < 200) begin
                cap[o_idx] = o_out;
                if (o_last) last_at = o_idx;
                nw++; k++;
                tick;
            end
            chk("tbl_word", cap[tbl[v].idx], tbl[v].exp);
            chk("tbl_count", 64'(nw), 64'(rounds));
            chk("tbl_last_at", 64'(last_at), 64'(rounds - 1));
            chk("tbl_idle", {63'b0, o_ready}, 64'd1);
        end

        // Random blocks against the reference model, both word sizes.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            rounds = (sel != 0) ? 80 : 64;
            for (int r = 0; r < 3; r++) begin
                rand_block; model; pack;
                offer;
                expect_stream(mw, 0, rounds - 1, 1);
            end
        end

        sel = 0;
        rounds = 64;
        #1;

        // Async reset mid-block at idx 20.
        rand_block; model; pack;
        offer;
        expect_stream(mw, 0, 19, 0);
        chk("pre_rst_idx", 64'(o_idx), 64'd20);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, o_valid}, 64'd0);
        chk("midrst_busy", {63'b0, o_busy}, 64'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("postrst_ready", {63'b0, o_ready}, 64'd1);
        chk("postrst_idx", 64'(o_idx), 64'd0);
        chk("postrst_valid", {63'b0, o_valid}, 64'd0);

        // Back-to-back blocks with blk_valid held high.
        rand_block; model; e_a = mw;
        pack;
        blk_valid = 1'b1;
        tick;
        rand_block; model; pack;
        expect_stream(e_a, 0, rounds - 1, 0);
        expect_stream(mw, 0, 0, 0);
        blk_valid = 1'b0;
        expect_stream(mw, 1, rounds - 1, 1);

        // Abort at idx 5 while a new block is offered.
        rand_block; model; e_a = mw; pack;
        offer;
        expect_stream(e_a, 0, 4, 0);
        rand_block; model; pack;
        abort = 1'b1;
        blk_valid = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_valid", {63'b0, o_valid}, 64'd0);
        chk("abort_busy", {63'b0, o_busy}, 64'd0);
        chk("abort_idx", 64'(o_idx), 64'd0);
        chk("abort_ready", {63'b0, o_ready}, 64'd1);
        tick;
        blk_valid = 1'b0;
        expect_stream(mw, 0, rounds - 1, 1);

`ifdef WSCHED_BACKPRESSURE_EN
        // Stall three cycles at idx 17.
        rand_block; model; pack;
        offer;
        expect_stream(mw, 0, 16, 0);
        w_ready = 1'b0;
        repeat (3) begin
            tick;
            chk("stall_idx", 64'(o_idx), 64'd17);
            chk("stall_out", o_out, mw[17]);
            chk("stall_valid", {63'b0, o_valid}, 64'd1);
        end
        w_ready = 1'b1;
        expect_stream(mw, 17, rounds - 1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
